// File: rtl/rslt_bram_writer.sv
// Result-stream to BRAM writer: lands AXI-Stream beats at consecutive word
// addresses and checks tlast lands exactly on the programmed result size.
module rslt_bram_writer #(
    parameter int DATA_WIDTH      = 16,
    parameter int WE_WIDTH        = DATA_WIDTH / 8,
    parameter int BRAM_ADDR_WIDTH = 12,
    parameter int SIZE_WIDTH      = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       operation_start,
    input  logic [SIZE_WIDTH-1:0]      rslt_size,
    input  logic [BRAM_ADDR_WIDTH-1:0] base_addr,
    input  logic [DATA_WIDTH-1:0]      s_axis_rslt_tdata,
    input  logic                       s_axis_rslt_tvalid,
    output logic                       s_axis_rslt_tready,
    input  logic                       s_axis_rslt_tlast,
    output logic                       bram_en,
    output logic [WE_WIDTH-1:0]        bram_we,
    output logic [BRAM_ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0]      bram_wrdata,
    output logic                       operation_in_progress,
    output logic                       operation_complete,
    output logic                       operation_error,
    output logic [SIZE_WIDTH-1:0]      words_written
);

    typedef enum logic [2:0] {
        IDLE, RUN, DRAIN, DONE, ERR
    } state_t;

    state_t                     state, next;
    logic [SIZE_WIDTH-1:0]      size_q;
    logic [SIZE_WIDTH-1:0]      cnt;
    logic [BRAM_ADDR_WIDTH-1:0] base_q;
    logic                       acc;
    logic                       at_end;
    logic                       wr;
    logic                       start_ok;

    assign acc      = s_axis_rslt_tvalid && s_axis_rslt_tready;
    assign at_end   = (cnt == size_q - SIZE_WIDTH'(1));
    assign wr       = (state == RUN) && acc;
    assign start_ok = (state == IDLE) && operation_start;

    always_comb begin
        next = state;
        unique case (state)
            IDLE: begin
                if (operation_start)
                    next = (rslt_size == '0) ? ERR : RUN;
            end
            RUN: begin
                if (acc) begin
                    if (at_end)
                        next = s_axis_rslt_tlast ? DONE : DRAIN;
                    else if (s_axis_rslt_tlast)
                        next = ERR;
                end
            end
            DRAIN: begin
                if (acc && s_axis_rslt_tlast)
                    next = ERR;
            end
            DONE:    next = IDLE;
            ERR:     next = IDLE;
            default: next = IDLE;
        endcase
    end

    // Status is decoded from next so each flag lines up with its state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state                 <= IDLE;
            s_axis_rslt_tready    <= 1'b0;
            operation_in_progress <= 1'b0;
            operation_complete    <= 1'b0;
            operation_error       <= 1'b0;
        end else begin
            state                 <= next;
            s_axis_rslt_tready    <= (next == RUN) || (next == DRAIN);
            operation_in_progress <= (next == RUN) || (next == DRAIN);
            operation_complete    <= (next == DONE);
            operation_error       <= (next == ERR);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            size_q        <= '0;
            base_q        <= '0;
            cnt           <= '0;
            words_written <= '0;
        end else if (start_ok) begin
            size_q        <= rslt_size;
            base_q        <= base_addr;
            cnt           <= '0;
            words_written <= '0;
        end else if (wr) begin
            cnt           <= cnt + SIZE_WIDTH'(1);
            words_written <= words_written + SIZE_WIDTH'(1);
        end
    end

    // Address wraps silently at the BRAM word-address width.
    always_ff @(posedge clk) begin
        if (rst) begin
            bram_en     <= 1'b0;
            bram_we     <= '0;
            bram_addr   <= '0;
            bram_wrdata <= '0;
        end else begin
            bram_en     <= wr;
            bram_we     <= {WE_WIDTH{wr}};
            bram_addr   <= wr ? base_q + cnt[BRAM_ADDR_WIDTH-1:0] : '0;
            bram_wrdata <= wr ? s_axis_rslt_tdata : '0;
        end
    end

endmodule

// File: tb/tb_rslt_bram_writer.sv
// Directed bench for rslt_bram_writer: normal, gapped, error, wrap
// and mid-operation reset scenarios.
module tb_rslt_bram_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        operation_start;
    logic [31:0] rslt_size;
    logic [11:0] base_addr;
    logic [15:0] s_axis_rslt_tdata;
    logic        s_axis_rslt_tvalid;
    logic        s_axis_rslt_tready;
    logic        s_axis_rslt_tlast;
    logic        bram_en;
    logic [1:0]  bram_we;
    logic [11:0] bram_addr;
    logic [15:0] bram_wrdata;
    logic        operation_in_progress;
    logic        operation_complete;
    logic        operation_error;
    logic [31:0] words_written;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int bad_we = 0;
    int ncomp  = 0;
    int nerr   = 0;

    logic [11:0] wa[$];
    logic [15:0] wd[$];
    int          wc[$];

    rslt_bram_writer dut (
        .clk                   (clk),
        .rst                   (rst),
        .operation_start       (operation_start),
        .rslt_size             (rslt_size),
        .base_addr             (base_addr),
        .s_axis_rslt_tdata     (s_axis_rslt_tdata),
        .s_axis_rslt_tvalid    (s_axis_rslt_tvalid),
        .s_axis_rslt_tready    (s_axis_rslt_tready),
        .s_axis_rslt_tlast     (s_axis_rslt_tlast),
        .bram_en               (bram_en),
        .bram_we               (bram_we),
        .bram_addr             (bram_addr),
        .bram_wrdata           (bram_wrdata),
        .operation_in_progress (operation_in_progress),
        .operation_complete    (operation_complete),
        .operation_error       (operation_error),
        .words_written         (words_written)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bram_en) begin
            wa.push_back(bram_addr);
            wd.push_back(bram_wrdata);
            wc.push_back(cyc);
            if (bram_we != 2'b11) bad_we++;
        end
        if (operation_complete) ncomp++;
        if (operation_error) nerr++;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
        wc.delete();
        ncomp = 0;
        nerr  = 0;
    endtask

    task automatic start(input logic [11:0] b, input logic [31:0] s);
        operation_start = 1'b1;
        base_addr       = b;
        rslt_size       = s;
        tick();
        operation_start = 1'b0;
    endtask

    task automatic send(input logic [15:0] d, input logic last);
        int n = 0;
        s_axis_rslt_tvalid = 1'b1;
        s_axis_rslt_tdata  = d;
        s_axis_rslt_tlast  = last;
        while (!s_axis_rslt_tready && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) check("tready_timeout", 32'd0, 32'd1);
        tick();
        s_axis_rslt_tvalid = 1'b0;
        s_axis_rslt_tlast  = 1'b0;
    endtask

    task automatic check_writes(input string tag, input logic [11:0] a0,
                                input logic [15:0] d0, input int n);
        logic [11:0] ea;
        check({tag, "_nwr"}, wa.size(), n);
        for (int i = 0; i < n && i < wa.size(); i++) begin
            ea = a0 + 12'(i);
            check({tag, "_addr"}, wa[i], ea);
            check({tag, "_data"}, wd[i], d0 + 16'(i));
        end
    endtask

    initial begin
        rst                = 1'b1;
        operation_start    = 1'b0;
        rslt_size          = '0;
        base_addr          = '0;
        s_axis_rslt_tdata  = '0;
        s_axis_rslt_tvalid = 1'b0;
        s_axis_rslt_tlast  = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        check("rst_tready", s_axis_rslt_tready, 0);
        check("rst_en", bram_en, 0);
        check("rst_we", bram_we, 0);
        check("rst_addr", bram_addr, 0);
        check("rst_wrdata", bram_wrdata, 0);
        check("rst_inprog", operation_in_progress, 0);
        check("rst_cmp", operation_complete, 0);
        check("rst_err", operation_error, 0);
        check("rst_words", words_written, 0);
        tick();

        // Normal, with a stray start mid-run that must be ignored
        clear_log();
        start(12'h010, 4);
        check("norm_tready", s_axis_rslt_tready, 1);
        check("norm_inprog", operation_in_progress, 1);
        send(16'h00A1, 0);
        operation_start = 1'b1;
        base_addr       = 12'h077;
        rslt_size       = 9;
        send(16'h00A2, 0);
        operation_start = 1'b0;
        send(16'h00A3, 0);
        send(16'h00A4, 1);
        check("norm_cmp", operation_complete, 1);
        check("norm_inprog_done", operation_in_progress, 0);
        check("norm_tready_done", s_axis_rslt_tready, 0);
        check("norm_words", words_written, 4);
        tick();
        check("norm_cmp_pulse", operation_complete, 0);
        tick();
        check_writes("norm", 12'h010, 16'h00A1, 4);
        if (wc.size() == 4) check("norm_b2b", wc[3] - wc[0], 3);
        check("norm_ncomp", ncomp, 1);
        check("norm_nerr", nerr, 0);

        // Same transfer with a gap between every beat
        clear_log();
        start(12'h010, 4);
        for (int i = 0; i < 4; i++) begin
            send(16'h00A1 + 16'(i), i == 3);
            if (i < 3) tick();
        end
        tick();
        tick();
        check_writes("gap", 12'h010, 16'h00A1, 4);
        check("gap_ncomp", ncomp, 1);
        check("gap_words", words_written, 4);

        // Zero size
        clear_log();
        start(12'h020, 0);
        check("zero_err", operation_error, 1);
        check("zero_tready", s_axis_rslt_tready, 0);
        tick();
        check("zero_err_pulse", operation_error, 0);
        check("zero_tready2", s_axis_rslt_tready, 0);
        tick();
        check("zero_nwr", wa.size(), 0);
        check("zero_nerr", nerr, 1);

        // Early tlast
        clear_log();
        start(12'h100, 4);
        send(16'h00B1, 0);
        send(16'h00B2, 1);
        check("early_err", operation_error, 1);
        check("early_tready", s_axis_rslt_tready, 0);
        check("early_words", words_written, 2);
        tick();
        tick();
        check_writes("early", 12'h100, 16'h00B1, 2);
        check("early_ncomp", ncomp, 0);

        // Missing tlast: drain until a late tlast
        clear_log();
        start(12'h200, 2);
        send(16'h00C1, 0);
        send(16'h00C2, 0);
        check("drain_inprog", operation_in_progress, 1);
        send(16'h00C3, 0);
        send(16'h00C4, 0);
        check("drain_inprog2", operation_in_progress, 1);
        send(16'h00C5, 1);
        check("drain_err", operation_error, 1);
        check("drain_inprog_err", operation_in_progress, 0);
        tick();
        tick();
        check_writes("drain", 12'h200, 16'h00C1, 2);
        check("drain_words", words_written, 2);
        check("drain_nerr", nerr, 1);

        // Address wrap
        clear_log();
        start(12'hFFE, 4);
        for (int i = 0; i < 4; i++) send(16'h00D1 + 16'(i), i == 3);
        tick();
        tick();
        check_writes("wrap", 12'hFFE, 16'h00D1, 4);
        check("wrap_ncomp", ncomp, 1);
        check("wrap_nerr", nerr, 0);

        // Reset mid-operation
        clear_log();
        start(12'h300, 8);
        send(16'h00E1, 0);
        send(16'h00E2, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_tready", s_axis_rslt_tready, 0);
        check("mrst_en", bram_en, 0);
        check("mrst_addr", bram_addr, 0);
        check("mrst_wrdata", bram_wrdata, 0);
        check("mrst_inprog", operation_in_progress, 0);
        check("mrst_words", words_written, 0);
        check("mrst_cmp", operation_complete, 0);
        check("mrst_err", operation_error, 0);
        clear_log();
        start(12'h400, 1);
        send(16'h00F1, 1);
        check("post_cmp", operation_complete, 1);
        check("post_words", words_written, 1);
        tick();
        tick();
        check_writes("post", 12'h400, 16'h00F1, 1);
        check("post_nerr", nerr, 0);
        check("we_all_ones", bad_we, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rslt_bram_writer.md
Name: rslt_bram_writer

Overview:
Write-side counterpart of the memory control unit's BRAM readers. Accepts one AXI-Stream result channel from the KAN datapath and writes each beat into result BRAM at consecutive word addresses from a programmable base. Checks that the tlast position matches the programmed result size. Reports in-progress, complete and error with the same semantics as the read-side control unit.

Parameters:
DATA_WIDTH, 16, result word width in bits (multiple of 8)
WE_WIDTH, DATA_WIDTH/8, BRAM byte-write-enable width
BRAM_ADDR_WIDTH, 12, BRAM word-address width
SIZE_WIDTH, 32, width of the result-size and word counters

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
operation_start  in  1  start pulse; sampled only in IDLE
rslt_size  in  SIZE_WIDTH  number of beats expected; latched on accepted start
base_addr  in  BRAM_ADDR_WIDTH  first word address; latched on accepted start
s_axis_rslt_tdata  in  DATA_WIDTH  result beat
s_axis_rslt_tvalid  in  1  beat valid
s_axis_rslt_tready  out  1  beat accepted when tvalid&&tready
s_axis_rslt_tlast  in  1  last beat of the result vector
bram_en  out  1  BRAM port enable
bram_we  out  WE_WIDTH  byte write enables, all ones or all zeros
bram_addr  out  BRAM_ADDR_WIDTH  word address
bram_wrdata  out  DATA_WIDTH  write data
operation_in_progress  out  1  high in RUN and DRAIN
operation_complete  out  1  one-cycle pulse on successful end
operation_error  out  1  one-cycle pulse on error
words_written  out  SIZE_WIDTH  beats written in current/last operation

Behaviour:
- Reset values:
  - state=IDLE
  - tready=0, bram_en=0, bram_we=0, bram_addr=0, bram_wrdata=0
  - all status outputs 0, words_written=0
- States: IDLE, RUN, DRAIN, DONE, ERR.
- IDLE:
  - tready=0.
  - operation_start=1 latches rslt_size and base_addr and clears the counter.
  - If rslt_size==0, go to ERR; otherwise go to RUN.
- RUN:
  - tready=1.
  - Each accepted beat: counter++, words_written++, write tdata at base+counter.
  - Accepted beat with counter==size-1 and tlast=1: go to DONE.
  - Accepted beat with counter==size-1 and tlast=0: the beat is still written; go to DRAIN (missing tlast).
  - Accepted beat with counter<size-1 and tlast=1: the beat is still written; go to ERR (early tlast).
  - tvalid=0 cycles: no state change, no write.
- DRAIN:
  - tready=1.
  - Beats are accepted and discarded; no BRAM writes and no counter change.
  - Accepted beat with tlast=1: go to ERR.
- DONE: operation_complete=1 for exactly one cycle, then IDLE. operation_start is ignored in this cycle.
- ERR: operation_error=1 for exactly one cycle, tready=0, then IDLE.
- Status outputs are registered and decoded from the next state, so they align with the state they describe.
- BRAM write timing:
  - Registered, latency 1: bram_en=1, bram_we=all ones, bram_addr and bram_wrdata are set in the cycle after the handshake.
  - Outputs are otherwise 0 the next cycle, so there is no spurious write.
  - Back-to-back beats produce back-to-back writes; the BRAM port never stalls (write-only, no backpressure).
- Address arithmetic: bram_addr = (base_addr + counter) mod 2^BRAM_ADDR_WIDTH; wrap is silent, not an error.
- words_written holds its value through IDLE and clears on the next accepted start.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values. A pending registered write is dropped (bram_en=0 next cycle). No complete or error pulse.
- operation_start while not in IDLE is ignored; the latched size/base are unaffected.

Test Plan:
- Normal: base=0x010, size=4, beats 0xA1..0xA4 with tlast on the 4th, tvalid continuous → writes 0x010..0x013 on consecutive cycles one cycle after each handshake; complete pulse 1 cycle; words_written=4.
- Backpressure-free gaps: same transfer with tvalid low every other cycle → identical BRAM contents; bram_en only in cycles after accepted beats; complete after the 4th beat.
- Error cases:
  - size=0 start → operation_error pulse on the 2nd cycle; no BRAM writes; tready stays 0.
  - size=4, tlast on beat 2 → two writes; error pulse; tready=0 in ERR; words_written=2.
  - size=2, tlast only on beat 5 → two writes, beats 3–5 accepted with no writes, then error pulse; in_progress high until ERR.
- Wrap: BRAM_ADDR_WIDTH=12, base=0xFFE, size=4 → addresses 0xFFE, 0xFFF, 0x000, 0x001; complete, no error.
- Reset: rst asserted after beat 2 of size 8 → next cycle all outputs 0 and state IDLE; a fresh start with size 1 then completes normally.
